// File: rtl/mapper_mem_pkg.sv
// Shared types and widths for the mapper memory arbiter.
package mapper_mem_pkg;

    localparam int unsigned ADDR_W = 22;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        RID_PPU,
        RID_CPU,
        RID_LDR
    } rid_t;

    // Command presented on the shared memory port for the whole WAIT phase
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mapper_mem_prio.sv
// Fixed PPU > CPU > LDR priority with a starvation escape that lets a pending CPU win
// after STARVE_LIMIT consecutive PPU grants.
module mapper_mem_prio
    import mapper_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic arb_en,
    input  logic ppu_req,
    input  logic cpu_req,
    input  logic ldr_req,
    output logic any_req_c,
    output rid_t winner_c
);

    logic [2:0] starve_q;
    logic       starved_c;

    assign starved_c = cpu_req && (starve_q == 3'(STARVE_LIMIT));
    assign any_req_c = ppu_req || cpu_req || ldr_req;

    always_comb begin
        winner_c = RID_LDR;
        if (starved_c) begin
            winner_c = RID_CPU;
        end else if (ppu_req) begin
            winner_c = RID_PPU;
        end else if (cpu_req) begin
            winner_c = RID_CPU;
        end
    end

    // Count PPU wins only while the CPU is actually waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= 3'd0;
        end else if (arb_en) begin
            if (!cpu_req || winner_c == RID_CPU) begin
                starve_q <= 3'd0;
            end else if (winner_c == RID_PPU) begin
                starve_q <= starve_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mapper_mem_arbiter.sv
// Arbitrates PPU, CPU and ROM-loader accesses onto one shared memory port, with a
// per-transaction timeout that completes the access with 0xFF read data.
module mapper_mem_arbiter
    import mapper_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_ack,
    output logic [DATA_W-1:0] ppu_rdata,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              timeout_err
);

    localparam int unsigned TMO_W = 8;

    state_t            state_q, state_d;
    rid_t              winner_c, owner_q;
    logic              any_req_c;
    logic              arb_en_c;
    logic              tmo_hit_c;
    logic              finish_c;
    logic [DATA_W-1:0] rd_c;
    logic [TMO_W-1:0]  tmo_q;
    mem_cmd_t          cmd_c, cmd_q;

    assign arb_en_c  = (state_q == ST_IDLE);
    assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign finish_c  = mem_ack || tmo_hit_c;
    assign rd_c      = mem_ack ? mem_rdata : 8'hFF;

    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

    mapper_mem_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk       (clk),
        .reset_n   (reset_n),
        .arb_en    (arb_en_c),
        .ppu_req   (ppu_req),
        .cpu_req   (cpu_req),
        .ldr_req   (ldr_req),
        .any_req_c (any_req_c),
        .winner_c  (winner_c)
    );

    // Command the winner would place on the memory port
    always_comb begin
        cmd_c = '0;
        case (winner_c)
            RID_PPU: begin
                cmd_c.we   = 1'b0;
                cmd_c.addr = ppu_addr;
            end
            RID_CPU: begin
                cmd_c.we    = cpu_we;
                cmd_c.addr  = cpu_addr;
                cmd_c.wdata = cpu_wdata;
            end
            default: begin
                cmd_c.we    = 1'b1;
                cmd_c.addr  = ldr_addr;
                cmd_c.wdata = ldr_wdata;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req_c) state_d = ST_WAIT;
            ST_WAIT: if (finish_c)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= RID_PPU;
            cmd_q       <= '0;
            tmo_q       <= '0;
            mem_req     <= 1'b0;
            ppu_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            ldr_ack     <= 1'b0;
            ppu_rdata   <= '0;
            cpu_rdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            ppu_ack <= 1'b0;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req_c) begin
                        owner_q <= winner_c;
                        cmd_q   <= cmd_c;
                        tmo_q   <= '0;
                        mem_req <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (finish_c) begin
                        mem_req <= 1'b0;
                        case (owner_q)
                            RID_PPU: ppu_ack <= 1'b1;
                            RID_CPU: cpu_ack <= 1'b1;
                            default: ldr_ack <= 1'b1;
                        endcase
                        // Only reads update the requester's data register
                        if (!cmd_q.we) begin
                            case (owner_q)
                                RID_PPU: ppu_rdata <= rd_c;
                                RID_CPU: cpu_rdata <= rd_c;
                                default: ;
                            endcase
                        end
                        if (!mem_ack) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mapper_mem_arbiter.sv
// Self-checking bench: table of single transactions plus starvation, loader and reset sequences.
module tb_mapper_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ppu_req = 1'b0;
    logic [21:0] ppu_addr = '0;
    logic        ppu_ack;
    logic [7:0]  ppu_rdata;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [21:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        ldr_req = 1'b0;
    logic [21:0] ldr_addr = '0;
    logic [7:0]  ldr_wdata = '0;
    logic        ldr_ack;
    logic        mem_req;
    logic        mem_we;
    logic [21:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        timeout_err;

    mapper_mem_arbiter #(.STARVE_LIMIT(3), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string act, input string exp);
        checks++;
        errors++;
        $display("FAIL %s actual=%s expected=%s", name, act, exp);
    endtask

    // Expectation records: rid 0 = PPU, 1 = CPU, 2 = LDR
    typedef struct {
        logic        we;
        logic [21:0] addr;
        logic [7:0]  wdata;
        int          len;
    } grant_t;

    typedef struct {
        int          rid;
        logic [7:0]  rdata;
        logic        tmo;
    } ack_t;

    grant_t gq[$];
    ack_t   aq[$];

    task automatic push_txn(input int rid, input logic we, input logic [21:0] addr,
                            input logic [7:0] wdata, input int len,
                            input logic [7:0] rdata, input logic tmo, input logic with_ack);
        grant_t g;
        ack_t   a;
        g.we = we; g.addr = addr; g.wdata = wdata; g.len = len;
        gq.push_back(g);
        if (with_ack) begin
            a.rid = rid; a.rdata = rdata; a.tmo = tmo;
            aq.push_back(a);
        end
    endtask

    // Memory model: ack in the mem_lat-th cycle of mem_req (0 = never)
    int         mem_lat = 0;
    int         req_cnt = 0;
    logic [7:0] mem_data = '0;
    logic       force_ack = 1'b0;

    always @(negedge clk) begin
        req_cnt   = mem_req ? req_cnt + 1 : 0;
        mem_ack   = force_ack || (mem_req && mem_lat != 0 && req_cnt == mem_lat);
        mem_rdata = mem_data;
    end

    // Monitor: pops grant expectations on mem_req rise, ack expectations on each ack
    logic   prev_req = 1'b0;
    grant_t cur_g;
    int     run_len = 0;
    logic   stable = 1'b1;

    always @(negedge clk) begin
        if (mem_req && !prev_req) begin
            if (gq.size() == 0) begin
                fail("grant_unexpected", "mem_req", "idle");
            end else begin
                cur_g = gq.pop_front();
                check("grant_we", 32'(mem_we), 32'(cur_g.we));
                check("grant_addr", 32'(mem_addr), 32'(cur_g.addr));
                if (cur_g.we) check("grant_wdata", 32'(mem_wdata), 32'(cur_g.wdata));
            end
            run_len = 0;
            stable  = 1'b1;
        end
        if (mem_req) begin
            run_len++;
            if (mem_we !== cur_g.we || mem_addr !== cur_g.addr) stable = 1'b0;
        end
        if (!mem_req && prev_req) begin
            if (cur_g.len >= 0) check("mem_req_len", 32'(run_len), 32'(cur_g.len));
            check("mem_stable", 32'(stable), 32'd1);
        end
        prev_req = mem_req;

        if ({ldr_ack, cpu_ack, ppu_ack} != 3'b000) begin
            if (aq.size() == 0) begin
                fail("ack_unexpected", "ack", "none");
            end else begin
                ack_t a;
                a = aq.pop_front();
                check("ack_onehot", 32'({ldr_ack, cpu_ack, ppu_ack}), 32'(3'b001 << a.rid));
                if (a.rid == 0) check("ppu_rdata", 32'(ppu_rdata), 32'(a.rdata));
                if (a.rid == 1) check("cpu_rdata", 32'(cpu_rdata), 32'(a.rdata));
                check("timeout_err", 32'(timeout_err), 32'(a.tmo));
            end
        end
    end

    int ppu_left = 0, cpu_left = 0, ldr_left = 0;

    // Waits for outstanding acks, dropping each req in its final ack cycle
    task automatic serve(input int max_cyc);
        int n;
        n = 0;
        while ((ppu_left + cpu_left + ldr_left) > 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (ppu_ack && ppu_left > 0) begin ppu_left--; if (ppu_left == 0) ppu_req = 1'b0; end
            if (cpu_ack && cpu_left > 0) begin cpu_left--; if (cpu_left == 0) cpu_req = 1'b0; end
            if (ldr_ack && ldr_left > 0) begin ldr_left--; if (ldr_left == 0) ldr_req = 1'b0; end
        end
        if ((ppu_left + cpu_left + ldr_left) > 0) begin
            fail("serve_timeout", "ack pending", "all acks");
            ppu_req = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
            ppu_left = 0; cpu_left = 0; ldr_left = 0;
        end
    endtask

    typedef struct {
        int          rid;
        logic        we;
        logic [21:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  mdata;
        int          lat;
        logic [7:0]  exp_rdata;
        logic        exp_tmo;
        int          exp_len;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vec_t v;
        logic ewe;

        vecs[0] = '{1, 1'b0, 22'h008000, 8'h00, 8'h5A, 3, 8'h5A, 1'b0, 3};
        vecs[1] = '{0, 1'b0, 22'h000123, 8'h00, 8'h3C, 1, 8'h3C, 1'b0, 1};
        vecs[2] = '{2, 1'b1, 22'h000010, 8'hA5, 8'hEE, 2, 8'h00, 1'b0, 2};
        vecs[3] = '{1, 1'b1, 22'h3FFFFF, 8'h77, 8'hEE, 2, 8'h5A, 1'b0, 2};
        vecs[4] = '{0, 1'b0, 22'h1ABCDE, 8'h00, 8'hC3, 4, 8'hC3, 1'b0, 4};
        vecs[5] = '{1, 1'b0, 22'h000400, 8'h00, 8'h99, 0, 8'hFF, 1'b1, 4};
        vecs[6] = '{0, 1'b0, 22'h2AAAAA, 8'h00, 8'h11, 1, 8'h11, 1'b1, 1};

        #3;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_acks", 32'({ldr_ack, cpu_ack, ppu_ack}), 32'd0);
        check("rst_ppu_rdata", 32'(ppu_rdata), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            @(posedge clk); #1;
            mem_lat  = v.lat;
            mem_data = v.mdata;
            ewe = (v.rid == 0) ? 1'b0 : (v.rid == 2) ? 1'b1 : v.we;
            push_txn(v.rid, ewe, v.addr, v.wdata, v.exp_len, v.exp_rdata, v.exp_tmo, 1'b1);
            case (v.rid)
                0: begin ppu_addr = v.addr; ppu_req = 1'b1; ppu_left = 1; end
                1: begin cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
                         cpu_req = 1'b1; cpu_left = 1; end
                default: begin ldr_addr = v.addr; ldr_wdata = v.wdata;
                               ldr_req = 1'b1; ldr_left = 1; end
            endcase
            serve(40);
        end

        // PPU and CPU held together: three PPU grants, then the CPU
        @(posedge clk); #1;
        mem_lat = 1; mem_data = 8'h42;
        for (int k = 0; k < 8; k++) begin
            if (k % 4 == 3) push_txn(1, 1'b0, 22'h000200, 8'h00, 1, 8'h42, 1'b1, 1'b1);
            else            push_txn(0, 1'b0, 22'h000100, 8'h00, 1, 8'h42, 1'b1, 1'b1);
        end
        ppu_addr = 22'h000100; cpu_addr = 22'h000200; cpu_we = 1'b0;
        ppu_req = 1'b1; cpu_req = 1'b1;
        ppu_left = 6; cpu_left = 2;
        serve(80);

        // Loader alone first, CPU arriving one cycle later waits its turn
        @(posedge clk); #1;
        mem_lat = 2; mem_data = 8'h66;
        push_txn(2, 1'b1, 22'h000010, 8'hA5, 2, 8'h00, 1'b1, 1'b1);
        push_txn(1, 1'b0, 22'h000300, 8'h00, 2, 8'h66, 1'b1, 1'b1);
        ldr_addr = 22'h000010; ldr_wdata = 8'hA5; ldr_req = 1'b1; ldr_left = 1;
        @(posedge clk); #1;
        cpu_addr = 22'h000300; cpu_we = 1'b0; cpu_req = 1'b1; cpu_left = 1;
        serve(40);

        // Reset in the middle of a PPU read, then a stray mem_ack
        @(posedge clk); #1;
        mem_lat = 0;
        push_txn(0, 1'b0, 22'h000777, 8'h00, -1, 8'h00, 1'b0, 1'b0);
        ppu_addr = 22'h000777; ppu_req = 1'b1;
        repeat (2) @(posedge clk);
        #1 ppu_req = 1'b0;
        @(negedge clk);
        check("wait_mem_req", 32'(mem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'd0);
        check("arst_timeout_err", 32'(timeout_err), 32'd0);
        check("arst_ppu_ack", 32'(ppu_ack), 32'd0);
        check("arst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1 force_ack = 1'b1;
        @(posedge clk); #1 force_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("late_ack_mem_req", 32'(mem_req), 32'd0);
            check("late_ack_ppu_ack", 32'(ppu_ack), 32'd0);
        end

        // Arbiter is back in IDLE and serves a normal read
        @(posedge clk); #1;
        mem_lat = 1; mem_data = 8'h3C;
        push_txn(0, 1'b0, 22'h000055, 8'h00, 1, 8'h3C, 1'b0, 1'b1);
        ppu_addr = 22'h000055; ppu_req = 1'b1; ppu_left = 1;
        serve(20);

        repeat (3) @(negedge clk);
        check("grant_queue_left", 32'(gq.size()), 32'd0);
        check("ack_queue_left", 32'(aq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mapper_mem_arbiter.md
MAPPER_MEM_ARBITER -- requirements
Module: mapper_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive PPU grants allowed while CPU is pending.
REQ-002 Parameter TIMEOUT_CYC, default 255: max WAIT cycles before abort; 8-bit range 1..255.
REQ-003 clk  in  1  single system clock; all logic on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ppu_req  in  1  PPU CHR read request (level); ppu_addr  in  22  CHR byte address.
REQ-006 ppu_ack  out  1  one-cycle completion pulse; ppu_rdata  out  8  CHR data, valid with ppu_ack.
REQ-007 cpu_req  in  1  CPU PRG request (level); cpu_we  in  1  1 = write; cpu_addr  in  22; cpu_wdata  in  8.
REQ-008 cpu_ack  out  1  completion pulse; cpu_rdata  out  8  read data, valid with cpu_ack.
REQ-009 ldr_req  in  1  ROM loader write request (level); ldr_addr  in  22; ldr_wdata  in  8; ldr_ack  out  1  completion pulse.
REQ-010 mem_req  out  1; mem_we  out  1; mem_addr  out  22; mem_wdata  out  8: shared memory port command.
REQ-011 mem_ack  in  1  memory completion pulse; mem_rdata  in  8  valid with mem_ack.
REQ-012 timeout_err  out  1  sticky: a memory transaction timed out.

Function
REQ-013 FSM states: IDLE, WAIT, DONE. IDLE with any request -> WAIT; WAIT on mem_ack or timeout -> DONE; DONE -> IDLE unconditionally.
REQ-014 In IDLE, winner, mem_we, mem_addr, and mem_wdata are registered; mem_req = 1 from the first WAIT cycle.
REQ-015 mem_req and all mem_* operands stay constant through WAIT; mem_req = 0 in DONE and IDLE.
REQ-016 Priority: PPU > CPU > LDR, subject to the starvation rule below.
REQ-017 Starvation counter (3 bits): increments on each PPU grant made while cpu_req = 1; when it equals STARVE_LIMIT, CPU wins the next arbitration; cleared on any CPU grant or whenever cpu_req = 0 in IDLE.
REQ-018 PPU and LDR grants always have mem_we = 0 and mem_we = 1 respectively; CPU grants copy cpu_we.
REQ-019 On mem_ack in WAIT, mem_rdata is latched into the winner's rdata register (reads only); writes leave rdata unchanged.
REQ-020 The winner's ack is high for exactly the DONE cycle; other acks stay 0.
REQ-021 Latency: request seen in IDLE at cycle 0 -> mem_req at cycle 1 -> mem_ack at cycle k -> requester ack at cycle k+1 -> next arbitration at cycle k+2.
REQ-022 A requester must drop req in its ack cycle; req still high in the following IDLE is a new transaction.
REQ-023 Timeout counter (8 bits) clears on entering WAIT and increments each WAIT cycle. Reaching TIMEOUT_CYC without mem_ack -> DONE, winner acked; a read returns rdata = 8'hFF; timeout_err is set.
REQ-024 mem_ack in the same cycle the timeout count is reached counts as a normal completion; no error.
REQ-025 mem_ack outside WAIT is ignored.
REQ-026 LDR may starve while PPU or CPU requests persist; this is accepted.

Reset
REQ-027 reset_n low asynchronously forces IDLE; all acks, mem_req, mem_we, and timeout_err = 0; mem_addr, mem_wdata, and all rdata = 0; both counters = 0.
REQ-028 Reset mid-WAIT drops mem_req immediately; no ack is issued for the aborted transaction.

Structure
REQ-029 Package mapper_mem_pkg holds: the state enum; the requester-id enum (RID_PPU, RID_CPU, RID_LDR); and constants ADDR_W = 22 and DATA_W = 8.
REQ-030 Sub-module mapper_mem_prio implements the priority selection and owns the starvation counter; the FSM, timeout logic, and datapath stay in the top module.

Verification
REQ-031 Single CPU read of 0x008000 with mem_ack 3 cycles after mem_req and mem_rdata 0x5A -> cpu_ack 1 cycle later with cpu_rdata = 0x5A; mem_req high for exactly 3 cycles.
REQ-032 ppu_req and cpu_req raised together and held (re-asserted after each ack), STARVE_LIMIT = 3 -> grant order PPU, PPU, PPU, CPU, PPU, ...
REQ-033 ldr_req held, ldr_addr 0x000010, ldr_wdata 0xA5, cpu_req raised one cycle later -> LDR granted first (mem_we = 1, mem_wdata = 0xA5); CPU granted next.
REQ-034 TIMEOUT_CYC = 4, CPU read with no mem_ack -> cpu_ack after 4 WAIT cycles, cpu_rdata = 0xFF, timeout_err = 1 until reset.
REQ-035 reset_n pulsed low during WAIT of a PPU read, then a late mem_ack -> no ppu_ack, mem_req = 0, FSM stays in IDLE.
